// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared constants for the CPU bus arbiter: state encodings, master ids and
// the arbitration helper used by the top-level FSM.
package cpu_bus_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_GRANT_I = 2'd1;
  localparam logic [1:0] ARB_GRANT_D = 2'd2;

  localparam logic ARB_MASTER_I = 1'b0;
  localparam logic ARB_MASTER_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = ARB_IDLE,
    ST_GRANT_I = ARB_GRANT_I,
    ST_GRANT_D = ARB_GRANT_D
  } arb_state_t;

  // Returns 1 when the data master should be granted this cycle.
  // A lone requester always wins; on a tie, round-robin picks the master
  // not served last, otherwise data has fixed priority.
  function automatic logic choose_data(input logic ibus_req,
                                       input logic dbus_req,
                                       input logic last_grant,
                                       input logic round_robin);
    if (ibus_req && dbus_req) begin
      return round_robin ? (last_grant == ARB_MASTER_I) : 1'b1;
    end
    return dbus_req;
  endfunction

endpackage

// File: rtl/cpu_bus_arbiter_timeout_counter.sv
// Wait-cycle counter for a granted transfer. Cleared while no grant is
// active, counts grant cycles, and flags expiry on the last allowed cycle.
module cpu_bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST_COUNT = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_reg;

  // Count grant cycles; saturate at the expiry value so it never wraps.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = enable && (count_reg == LAST_COUNT);

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Merges the CPU instruction and data buses onto one system memory bus.
// One master is granted at a time and keeps the grant until i_bus_ready
// (or the optional wait timeout). Data wins ties unless the build defines
// CPU_BUS_ARBITER_ROUND_ROBIN_EN, which alternates on simultaneous requests.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_ibus_request,
  output logic        o_ibus_ready,
  input  logic [31:0] i_ibus_address,
  output logic [31:0] o_ibus_rdata,
  input  logic        i_dbus_rw,
  input  logic        i_dbus_request,
  output logic        o_dbus_ready,
  input  logic [31:0] i_dbus_address,
  output logic [31:0] o_dbus_rdata,
  input  logic [31:0] i_dbus_wdata,
  output logic        o_bus_rw,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_bus_wdata,
  output logic        o_timeout
);

  arb_state_t  state_reg, state_next;
  logic        bus_request_reg, bus_request_next;
  logic        bus_rw_reg, bus_rw_next;
  logic [31:0] bus_address_reg, bus_address_next;
  logic [31:0] bus_wdata_reg, bus_wdata_next;
  logic        timeout_reg, timeout_next;

  logic granted;
  logic timeout_hit;
  logic timeout_forced;
  logic transfer_done;
  logic grant_data;

  assign granted        = (state_reg != ST_IDLE);
  assign timeout_forced = granted && timeout_hit && !i_bus_ready;
  assign transfer_done  = granted && (i_bus_ready || timeout_hit);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      logic expired;
      cpu_bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
      ) u_timeout_counter (
        .clock   (i_clock),
        .reset_n (i_reset_n),
        .clear   (!granted),
        .enable  (granted),
        .expired (expired)
      );
      assign timeout_hit = expired;
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
  logic last_grant_reg, last_grant_next;

  // Remember which master was served last so ties alternate.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_grant_reg <= ARB_MASTER_I;
    end else begin
      last_grant_reg <= last_grant_next;
    end
  end

  assign grant_data = choose_data(i_ibus_request, i_dbus_request, last_grant_reg, 1'b1);
`else
  assign grant_data = choose_data(i_ibus_request, i_dbus_request, ARB_MASTER_I, 1'b0);
`endif

  // State and registered bus-side outputs; reset drops the request at once.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg       <= ST_IDLE;
      bus_request_reg <= 1'b0;
      bus_rw_reg      <= 1'b0;
      bus_address_reg <= '0;
      bus_wdata_reg   <= '0;
      timeout_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bus_request_reg <= bus_request_next;
      bus_rw_reg      <= bus_rw_next;
      bus_address_reg <= bus_address_next;
      bus_wdata_reg   <= bus_wdata_next;
      timeout_reg     <= timeout_next;
    end
  end

  // Arbitrate in IDLE, latch the winner's transfer, and hold it until done.
  always_comb begin
    state_next       = state_reg;
    bus_rw_next      = bus_rw_reg;
    bus_address_next = bus_address_reg;
    bus_wdata_next   = bus_wdata_reg;
    timeout_next     = timeout_reg;
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
    last_grant_next  = last_grant_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (grant_data) begin
          state_next       = ST_GRANT_D;
          bus_rw_next      = i_dbus_rw;
          bus_address_next = i_dbus_address;
          bus_wdata_next   = i_dbus_wdata;
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
          last_grant_next  = ARB_MASTER_D;
`endif
        end else if (i_ibus_request) begin
          state_next       = ST_GRANT_I;
          bus_rw_next      = 1'b0;
          bus_address_next = i_ibus_address;
          bus_wdata_next   = '0;
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
          last_grant_next  = ARB_MASTER_I;
`endif
        end
      end
      ST_GRANT_I, ST_GRANT_D: begin
        if (transfer_done) begin
          state_next = ST_IDLE;
        end
        if (timeout_forced) begin
          timeout_next = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    bus_request_next = (state_next != ST_IDLE);
  end

  // Route completion and read data back to the granted master only.
  always_comb begin
    o_ibus_ready = 1'b0;
    o_dbus_ready = 1'b0;
    o_ibus_rdata = '0;
    o_dbus_rdata = '0;
    if (state_reg == ST_GRANT_I) begin
      o_ibus_ready = transfer_done;
      o_ibus_rdata = timeout_forced ? 32'd0 : i_bus_rdata;
    end else if (state_reg == ST_GRANT_D) begin
      o_dbus_ready = transfer_done;
      o_dbus_rdata = timeout_forced ? 32'd0 : i_bus_rdata;
    end
  end

  assign o_bus_request = bus_request_reg;
  assign o_bus_rw      = bus_rw_reg;
  assign o_bus_address = bus_address_reg;
  assign o_bus_wdata   = bus_wdata_reg;
  assign o_timeout     = timeout_reg;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter. A second instance with TIMEOUT_CYCLES=4
// covers the wait timeout; both share clock, reset and address/data inputs.
module tb_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ireq, dreq, rw, bus_ready;
  logic [31:0] iaddr, daddr, wdata, bus_rdata;
  logic        to_ireq, to_dreq, to_bus_ready;

  logic        ibus_ready, dbus_ready, bus_rw, bus_request, timeout;
  logic [31:0] ibus_rdata, dbus_rdata, bus_address, bus_wdata;
  logic        to_ibus_ready, to_dbus_ready, to_bus_rw, to_bus_request, to_timeout;
  logic [31:0] to_ibus_rdata, to_dbus_rdata, to_bus_address, to_bus_wdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_bus_arbiter #(.TIMEOUT_CYCLES(0)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_ibus_request(ireq), .o_ibus_ready(ibus_ready),
    .i_ibus_address(iaddr), .o_ibus_rdata(ibus_rdata),
    .i_dbus_rw(rw), .i_dbus_request(dreq), .o_dbus_ready(dbus_ready),
    .i_dbus_address(daddr), .o_dbus_rdata(dbus_rdata), .i_dbus_wdata(wdata),
    .o_bus_rw(bus_rw), .o_bus_request(bus_request), .i_bus_ready(bus_ready),
    .o_bus_address(bus_address), .i_bus_rdata(bus_rdata),
    .o_bus_wdata(bus_wdata), .o_timeout(timeout)
  );

  cpu_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut_to (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_ibus_request(to_ireq), .o_ibus_ready(to_ibus_ready),
    .i_ibus_address(iaddr), .o_ibus_rdata(to_ibus_rdata),
    .i_dbus_rw(rw), .i_dbus_request(to_dreq), .o_dbus_ready(to_dbus_ready),
    .i_dbus_address(daddr), .o_dbus_rdata(to_dbus_rdata), .i_dbus_wdata(wdata),
    .o_bus_rw(to_bus_rw), .o_bus_request(to_bus_request), .i_bus_ready(to_bus_ready),
    .o_bus_address(to_bus_address), .i_bus_rdata(bus_rdata),
    .o_bus_wdata(to_bus_wdata), .o_timeout(to_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One granted transfer with requests already presented: check the grant,
  // complete it with ready, then drop the winner's request.
  task automatic serve(input logic exp_d, input logic [31:0] rdata);
    step();
    chk("grant_req", 32'(bus_request), 32'd1);
    chk("grant_rw", 32'(bus_rw), 32'(exp_d));
    chk("grant_addr", bus_address, exp_d ? 32'h20 : 32'h10);
    bus_ready = 1'b1;
    bus_rdata = rdata;
    #1;
    chk("ready_i", 32'(ibus_ready), 32'(!exp_d));
    chk("ready_d", 32'(dbus_ready), 32'(exp_d));
    chk("rdata_granted", exp_d ? dbus_rdata : ibus_rdata, rdata);
    chk("rdata_other", exp_d ? ibus_rdata : dbus_rdata, 32'd0);
    step();
    bus_ready = 1'b0;
    if (exp_d) dreq = 1'b0; else ireq = 1'b0;
    chk("idle_after", 32'(bus_request), 32'd0);
    $display("transfer: master=%s rdata=%h", exp_d ? "D" : "I", rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ireq = 0; dreq = 0; rw = 0; bus_ready = 0;
    iaddr = '0; daddr = '0; wdata = '0; bus_rdata = '0;
    to_ireq = 0; to_dreq = 0; to_bus_ready = 0;
    step(); step();
    chk("rst_req", 32'(bus_request), 32'd0);
    chk("rst_addr", bus_address, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_to_timeout", 32'(to_timeout), 32'd0);
    rst_n = 1'b1;
    step();
    $display("reset: done");

    // 1. Single instruction fetch, ready two cycles after grant
    ireq = 1; iaddr = 32'h100;
    step();
    chk("t1_req", 32'(bus_request), 32'd1);
    chk("t1_addr", bus_address, 32'h100);
    chk("t1_rw", 32'(bus_rw), 32'd0);
    chk("t1_ready_early", 32'(ibus_ready), 32'd0);
    step();
    chk("t1_ready_wait", 32'(ibus_ready), 32'd0);
    bus_ready = 1; bus_rdata = 32'hDEADBEEF;
    #1;
    chk("t1_iready", 32'(ibus_ready), 32'd1);
    chk("t1_irdata", ibus_rdata, 32'hDEADBEEF);
    chk("t1_dready", 32'(dbus_ready), 32'd0);
    step();
    bus_ready = 0; ireq = 0;
    chk("t1_idle", 32'(bus_request), 32'd0);
    chk("t1_iready_end", 32'(ibus_ready), 32'd0);
    $display("transfer: single ifetch addr=100");

    // 2. Simultaneous requests: data first, instruction after one idle cycle
    ireq = 1; iaddr = 32'h10;
    dreq = 1; rw = 1; daddr = 32'h20; wdata = 32'h55;
    step();
    chk("t2_wdata", bus_wdata, 32'h55);
    chk("t2_rw", 32'(bus_rw), 32'd1);
    chk("t2_addr", bus_address, 32'h20);
    bus_ready = 1; bus_rdata = 32'h0;
    #1;
    chk("t2_dready", 32'(dbus_ready), 32'd1);
    chk("t2_iready", 32'(ibus_ready), 32'd0);
    step();
    bus_ready = 0; dreq = 0;
    chk("t2_idle", 32'(bus_request), 32'd0);
    serve(1'b0, 32'h12345678);

    // 3. Repeated ties: D then re-assert D against a waiting I
    ireq = 1; dreq = 1;
    serve(1'b1, 32'h0BAD0001);
    dreq = 1;
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
    serve(1'b0, 32'h0BAD0002);
    serve(1'b1, 32'h0BAD0003);
`else
    serve(1'b1, 32'h0BAD0002);
    serve(1'b0, 32'h0BAD0003);
`endif

    // 4. Store stability while the bus stalls
    dreq = 1; rw = 1; daddr = 32'h40; wdata = 32'h55;
    step();
    for (int k = 0; k < 5; k++) begin
      wdata = 32'hA0 + 32'(k);
      daddr = 32'h900 + 32'(k);
      step();
      chk("t4_wdata", bus_wdata, 32'h55);
      chk("t4_addr", bus_address, 32'h40);
      chk("t4_req", 32'(bus_request), 32'd1);
      chk("t4_dready", 32'(dbus_ready), 32'd0);
    end
    bus_ready = 1;
    #1;
    chk("t4_dready_end", 32'(dbus_ready), 32'd1);
    step();
    bus_ready = 0; dreq = 0;
    chk("t4_idle", 32'(bus_request), 32'd0);
    $display("transfer: stalled store addr=40 wdata=55");

    // 5. Timeout on the TIMEOUT_CYCLES=4 instance
    to_dreq = 1; rw = 0; daddr = 32'h60; bus_rdata = 32'hCAFEF00D;
    step();
    chk("t5_req", 32'(to_bus_request), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("t5_no_ready", 32'(to_dbus_ready), 32'd0);
      chk("t5_no_timeout", 32'(to_timeout), 32'd0);
      step();
    end
    chk("t5_forced_ready", 32'(to_dbus_ready), 32'd1);
    chk("t5_forced_rdata", to_dbus_rdata, 32'd0);
    chk("t5_iready", 32'(to_ibus_ready), 32'd0);
    step();
    to_dreq = 0;
    chk("t5_timeout", 32'(to_timeout), 32'd1);
    chk("t5_idle", 32'(to_bus_request), 32'd0);
    to_bus_ready = 1;
    #1;
    chk("t5_late_ready", 32'(to_dbus_ready), 32'd0);
    step();
    to_bus_ready = 0;
    chk("t5_late_idle", 32'(to_bus_request), 32'd0);
    step(); step();
    chk("t5_sticky", 32'(to_timeout), 32'd1);
    $display("transfer: timeout on stalled read");

    // 6. Asynchronous reset in the middle of a data grant
    dreq = 1; rw = 1; daddr = 32'h80; wdata = 32'h77;
    step();
    chk("t6_req", 32'(bus_request), 32'd1);
    #2;
    rst_n = 0;
    bus_ready = 1;
    #1;
    chk("t6_req_drop", 32'(bus_request), 32'd0);
    chk("t6_no_ready", 32'(dbus_ready), 32'd0);
    chk("t6_addr_clr", bus_address, 32'd0);
    chk("t6_to_clr", 32'(to_timeout), 32'd0);
    dreq = 0; bus_ready = 0;
    step();
    rst_n = 1;
    ireq = 1; iaddr = 32'h200;
    step();
    chk("t6_ireq", 32'(bus_request), 32'd1);
    chk("t6_iaddr", bus_address, 32'h200);
    chk("t6_irw", 32'(bus_rw), 32'd0);
    bus_ready = 1; bus_rdata = 32'hA5A5A5A5;
    #1;
    chk("t6_iready", 32'(ibus_ready), 32'd1);
    chk("t6_irdata", ibus_rdata, 32'hA5A5A5A5);
    chk("t6_dready", 32'(dbus_ready), 32'd0);
    step();
    bus_ready = 0; ireq = 0;
    chk("t6_idle", 32'(bus_request), 32'd0);
    $display("transfer: ifetch after mid-grant reset addr=200");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
